// File: rtl/ps2_ssd_entry_display_if.sv
// ----------------------------------------------------------------------------
// ps2_ssd_entry_display_if
// Key event bus from the PS/2 key decoder into the entry/display block.
//   last_change : scan code of the latest key, bit 8 = E0 extended prefix
//   key_valid   : one-cycle pulse, last_change holds a new make code
// master = key decoder side (drives), slave = entry/display side (samples).
// ----------------------------------------------------------------------------
interface ps2_ssd_entry_display_if;
  logic [8:0] last_change;
  logic       key_valid;

  modport master (output last_change, output key_valid);
  modport slave  (input  last_change, input  key_valid);
endinterface

// File: rtl/ps2_ssd_entry_display.sv
// ----------------------------------------------------------------------------
// ps2_ssd_entry_display
// Multi-digit decimal entry buffer fed by PS/2 make codes, shown on a
// time-multiplexed common-anode seven-segment bank.
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   key_if      : key event bus (slave) - last_change[8:0], key_valid
//   ssd_ctl     : digit enables, active-low, bit 0 = rightmost digit
//   ssd_seg     : segments {a,b,c,d,e,f,g,dp}, active-low
//   digit_count : digits currently held, 0..DIGITS
//   full        : digit_count == DIGITS
//   op          : latched operator, 0 none / 1 A / 2 S / 3 M
// Parameters: DIGITS (1..8) buffer depth and digit count,
//             SCAN_CYCLES (>= 2) cycles each digit stays enabled.
// ----------------------------------------------------------------------------
module ps2_ssd_entry_display #(
  parameter int DIGITS      = 4,
  parameter int SCAN_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ps2_ssd_entry_display_if.slave   key_if,
  output logic [DIGITS-1:0]        ssd_ctl,
  output logic [7:0]               ssd_seg,
  output logic [3:0]               digit_count,
  output logic                     full,
  output logic [1:0]               op
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_CYCLES);

  // Active-low {a,b,c,d,e,f,g,dp}, dp off.
  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'b0000_0011;
      4'd1:    p = 8'b1001_1111;
      4'd2:    p = 8'b0010_0101;
      4'd3:    p = 8'b0000_1101;
      4'd4:    p = 8'b1001_1001;
      4'd5:    p = 8'b0100_1001;
      4'd6:    p = 8'b0100_0001;
      4'd7:    p = 8'b0001_1111;
      4'd8:    p = 8'b0000_0001;
      4'd9:    p = 8'b0000_1001;
      default: p = 8'b1111_1111;
    endcase
    return p;
  endfunction

  logic [DIGITS*4-1:0] buf_p0;
  logic [3:0]          count_p0;
  logic [1:0]          op_p0;
  logic [CNT_W-1:0]    scan_cnt;
  logic [IDX_W-1:0]    idx;

  logic                is_digit;
  logic                is_bksp;
  logic                is_enter;
  logic                is_op;
  logic [3:0]          digit_val;
  logic [1:0]          op_val;

  // Key decode: extended codes and unlisted codes decode to nothing.
  always_comb begin
    is_digit  = 1'b0;
    is_bksp   = 1'b0;
    is_enter  = 1'b0;
    is_op     = 1'b0;
    digit_val = 4'd0;
    op_val    = 2'd0;
    if (key_if.key_valid && !key_if.last_change[8]) begin
      case (key_if.last_change[7:0])
        8'h45: begin is_digit = 1'b1; digit_val = 4'd0; end
        8'h16: begin is_digit = 1'b1; digit_val = 4'd1; end
        8'h1E: begin is_digit = 1'b1; digit_val = 4'd2; end
        8'h26: begin is_digit = 1'b1; digit_val = 4'd3; end
        8'h25: begin is_digit = 1'b1; digit_val = 4'd4; end
        8'h2E: begin is_digit = 1'b1; digit_val = 4'd5; end
        8'h36: begin is_digit = 1'b1; digit_val = 4'd6; end
        8'h3D: begin is_digit = 1'b1; digit_val = 4'd7; end
        8'h3E: begin is_digit = 1'b1; digit_val = 4'd8; end
        8'h46: begin is_digit = 1'b1; digit_val = 4'd9; end
        8'h66: is_bksp  = 1'b1;
        8'h5A: is_enter = 1'b1;
        8'h1C: begin is_op = 1'b1; op_val = 2'd1; end
        8'h1B: begin is_op = 1'b1; op_val = 2'd2; end
        8'h3A: begin is_op = 1'b1; op_val = 2'd3; end
        default: ;
      endcase
    end
  end

  assign full        = (count_p0 == 4'(DIGITS));
  assign digit_count = count_p0;
  assign op          = op_p0;

  // ---- stage p0: entry buffer, count and operator update on the key edge ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_p0   <= '0;
      count_p0 <= '0;
      op_p0    <= '0;
    end else if (is_enter) begin
      buf_p0   <= '0;
      count_p0 <= '0;
      op_p0    <= '0;
    end else if (is_digit && !full) begin
      // Entry 0 is the low nibble, so a left shift ages every digit by one slot.
      buf_p0   <= (buf_p0 << 4) | (DIGITS*4)'(digit_val);
      count_p0 <= count_p0 + 4'd1;
    end else if (is_bksp && (count_p0 != 4'd0)) begin
      buf_p0   <= buf_p0 >> 4;
      count_p0 <= count_p0 - 4'd1;
    end else if (is_op) begin
      op_p0    <= op_val;
    end
  end

  // Refresh scan: idx advances each time scan_cnt wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_CYCLES - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [3:0] sel_digit;
  logic [7:0] slot_seg;

  always_comb begin
    sel_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) sel_digit = buf_p0[i*4 +: 4];
    end
    slot_seg = (4'(idx) >= count_p0) ? 8'hFF : seg_pattern(sel_digit);
    // Operator indicator lives on the rightmost dp, even over a blank slot.
    if ((op_p0 != 2'd0) && (idx == '0)) slot_seg[0] = 1'b0;
  end

  // ---- stage p1: digit enable and segments registered from the same idx ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ssd_ctl <= '1;
      ssd_seg <= 8'hFF;
    end else begin
      ssd_ctl <= ~(DIGITS'(1) << idx);
      ssd_seg <= slot_seg;
    end
  end

endmodule

// File: tb/tb_ps2_ssd_entry_display.sv
// ----------------------------------------------------------------------------
// tb_ps2_ssd_entry_display
// Self-checking bench for ps2_ssd_entry_display with DIGITS = 4,
// SCAN_CYCLES = 4. A queue-based model of the typed number and operator
// predicts digit_count/full/op and the pattern of every scanned slot.
// ----------------------------------------------------------------------------
module tb_ps2_ssd_entry_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ssd_ctl;
  logic [7:0] ssd_seg;
  logic [3:0] digit_count;
  logic       full;
  logic [1:0] op;

  ps2_ssd_entry_display_if key_if ();

  ps2_ssd_entry_display #(.DIGITS(4), .SCAN_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_if      (key_if),
    .ssd_ctl     (ssd_ctl),
    .ssd_seg     (ssd_seg),
    .digit_count (digit_count),
    .full        (full),
    .op          (op)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scanned slot follows from it directly.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: typed digits oldest first, plus latched operator.
  int mq[$];
  int mop = 0;

  logic [7:0] pat  [10] = '{8'b0000_0011, 8'b1001_1111, 8'b0010_0101,
                            8'b0000_1101, 8'b1001_1001, 8'b0100_1001,
                            8'b0100_0001, 8'b0001_1111, 8'b0000_0001,
                            8'b0000_1001};
  logic [7:0] dcode[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                            8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (dcode[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [7:0] exp_seg(input int slot);
    logic [7:0] s;
    s = (slot < mq.size()) ? pat[mq[mq.size() - 1 - slot]] : 8'hFF;
    if (slot == 0 && mop != 0) s[0] = 1'b0;
    return s;
  endfunction

  task automatic model_apply(input logic [8:0] code);
    int d;
    if (code[8]) return;
    d = digit_of(code[7:0]);
    if (d >= 0) begin
      if (mq.size() < 4) mq.push_back(d);
    end else begin
      case (code[7:0])
        8'h66: if (mq.size() > 0) void'(mq.pop_back());
        8'h1C: mop = 1;
        8'h1B: mop = 2;
        8'h3A: mop = 3;
        8'h5A: begin mq.delete(); mop = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mop = 0;
  endtask

  // Drive one key for one edge; key_valid stays high so calls can chain.
  task automatic send_key(input logic [8:0] code);
    @(negedge clk);
    key_if.last_change = code;
    key_if.key_valid   = 1'b1;
    model_apply(code);
  endtask

  task automatic idle();
    @(negedge clk);
    key_if.key_valid = 1'b0;
  endtask

  task automatic key1(input logic [8:0] code);
    send_key(code);
    idle();
  endtask

  task automatic check_state(input string tag);
    n_checks++;
    if (digit_count !== 4'(mq.size()))
      $display("FAIL %s digit_count: got %0d expected %0d", tag, digit_count, mq.size());
    else n_pass++;
    n_checks++;
    if (full !== (mq.size() == 4))
      $display("FAIL %s full: got %b expected %b", tag, full, (mq.size() == 4));
    else n_pass++;
    n_checks++;
    if (op !== 2'(mop))
      $display("FAIL %s op: got %0d expected %0d", tag, op, mop);
    else n_pass++;
  endtask

  task automatic check_display(input string tag, input int ncyc);
    int ei;
    logic [3:0] ectl;
    logic [7:0] eseg;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      ei   = ((cyc - 1) / 4) % 4;
      ectl = ~(4'b0001 << ei);
      eseg = exp_seg(ei);
      n_checks++;
      if (ssd_ctl !== ectl)
        $display("FAIL %s ssd_ctl cyc %0d: got %b expected %b", tag, cyc, ssd_ctl, ectl);
      else n_pass++;
      n_checks++;
      if (ssd_seg !== eseg)
        $display("FAIL %s ssd_seg slot %0d: got %b expected %b", tag, ei, ssd_seg, eseg);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_if.key_valid = 1'b0;
    key_if.last_change = 9'h000;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ssd_ctl !== 4'b1111) $display("FAIL reset ssd_ctl: got %b expected 1111", ssd_ctl);
    else n_pass++;
    n_checks++;
    if (ssd_seg !== 8'hFF) $display("FAIL reset ssd_seg: got %h expected ff", ssd_seg);
    else n_pass++;
    model_clear();
    check_state("reset");
    rst_n = 1'b1;
    check_display("idle_scan", 20);
    check_state("idle");
  endtask

  task automatic test_digits();
    key1(9'h016); key1(9'h01E); key1(9'h026);
    check_state("digits123");
    check_display("digits123", 16);
  endtask

  task automatic test_full();
    key1(9'h05A);
    key1(9'h016); key1(9'h01E); key1(9'h026); key1(9'h025);
    check_state("full4");
    key1(9'h02E);
    check_state("full_drop");
    check_display("full", 16);
  endtask

  task automatic test_backspace();
    key1(9'h05A);
    key1(9'h016); key1(9'h01E); key1(9'h026);
    key1(9'h066);
    check_state("bksp1");
    check_display("bksp1", 16);
    key1(9'h066); key1(9'h066); key1(9'h066);
    check_state("bksp_underflow");
    check_display("bksp_empty", 16);
  endtask

  task automatic test_op_enter();
    key1(9'h016); key1(9'h03A);
    check_state("op_m");
    check_display("op_m", 16);
    key1(9'h05A);
    check_state("enter");
    key1(9'h01B);
    check_state("op_s_blank");
    check_display("op_s_blank", 16);
    key1(9'h05A);
    check_display("enter", 16);
  endtask

  task automatic test_ignored();
    key1(9'h016); key1(9'h01E);
    key1(9'h145);
    check_state("ignore_ext");
    key1(9'h029);
    check_state("ignore_unlisted");
    key1(9'h166);
    check_state("ignore_ext_bksp");
    check_display("ignored", 16);
  endtask

  task automatic test_reset_wins();
    @(negedge clk);
    rst_n = 1'b0;
    key_if.last_change = 9'h016;
    key_if.key_valid   = 1'b1;
    @(negedge clk);
    key_if.key_valid = 1'b0;
    model_clear();
    n_checks++;
    if (ssd_ctl !== 4'b1111) $display("FAIL rstwin ssd_ctl: got %b expected 1111", ssd_ctl);
    else n_pass++;
    check_state("rstwin");
    rst_n = 1'b1;
    check_display("rstwin", 16);
  endtask

  task automatic test_back_to_back();
    send_key(9'h05A);
    send_key(9'h03E); send_key(9'h046); send_key(9'h045);
    send_key(9'h066); send_key(9'h036); send_key(9'h01C);
    idle();
    check_state("b2b");
    check_display("b2b", 16);
  endtask

  task automatic test_random();
    logic [8:0] code;
    int r;
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 15);
      if (r < 10)       code = {1'b0, dcode[r]};
      else if (r == 10) code = 9'h066;
      else if (r == 11) begin
        case ($urandom_range(0, 2))
          0:       code = 9'h01C;
          1:       code = 9'h01B;
          default: code = 9'h03A;
        endcase
      end
      else if (r == 12) code = 9'h05A;
      else if (r == 13) code = 9'h029;
      else if (r == 14) code = {1'b1, dcode[$urandom_range(0, 9)]};
      else              code = 9'h166;
      send_key(code);
      if ($urandom_range(0, 2) != 0) begin
        idle();
        check_state("random");
      end
      if (k % 20 == 19) begin
        idle();
        check_display("random", 16);
      end
    end
    idle();
    check_state("random_end");
    check_display("random_end", 16);
  endtask

  initial begin
    key_if.key_valid = 1'b0;
    key_if.last_change = 9'h000;
    test_reset();
    test_digits();
    test_full();
    test_backspace();
    test_op_enter();
    test_ignored();
    test_reset_wins();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
